mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 91 +++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Grants and memory drive are combinational; read data returns one cycle after a read grant.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  writeEnable0,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [WIDTH-1:0]      writeData0,
  output logic                  grant0,
  output logic [WIDTH-1:0]      readData0,
  output logic                  readValid0,
  input  logic                  req1,
  input  logic                  writeEnable1,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [WIDTH-1:0]      writeData1,
  output logic                  grant1,
  output logic [WIDTH-1:0]      readData1,
  output logic                  readValid1,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [WIDTH-1:0]      memWriteData,
  input  logic [WIDTH-1:0]      memReadData
);

  logic r_last_grant;
  logic r_resp_pending;
  logic r_resp_id;

  logic w_grant0;
  logic w_grant1;
  logic w_any_grant;

  // Grants are held off while reset is asserted so every output reads 0 in reset.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        w_grant0 = r_last_grant;
        w_grant1 = ~r_last_grant;
      end else begin
        w_grant0 = req0;
        w_grant1 = req1;
      end
    end
  end

  assign w_any_grant = w_grant0 | w_grant1;
  assign grant0      = w_grant0;
  assign grant1      = w_grant1;

  always_comb begin
    memWriteEnable = 1'b0;
    memAddress     = '0;
    memWriteData   = '0;
    if (w_grant0) begin
      memWriteEnable = writeEnable0;
      memAddress     = address0;
      memWriteData   = writeData0;
    end else if (w_grant1) begin
      memWriteEnable = writeEnable1;
      memAddress     = address1;
      memWriteData   = writeData1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant   <= 1'b1;
      r_resp_pending <= 1'b0;
      r_resp_id      <= 1'b0;
    end else begin
      if (w_any_grant) begin
        r_last_grant <= w_grant1;
      end
      r_resp_pending <= w_any_grant & ~memWriteEnable;
      r_resp_id      <= w_grant1;
    end
  end

  // Memory output is passed straight through to whichever requester owns the response.
  assign readValid0 = r_resp_pending & ~r_resp_id;
  assign readValid1 = r_resp_pending & r_resp_id;
  assign readData0  = readValid0 ? memReadData : '0;
  assign readData1  = readValid1 ? memReadData : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: arbitration model, shadow memory and a read-response
// scoreboard, with a behavioural one-cycle-latency memory attached to the arbiter.
module tb_mem_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, writeEnable0, req1, writeEnable1;
  logic [AW-1:0] address0, address1;
  logic [DW-1:0] writeData0, writeData1;
  logic          grant0, grant1, readValid0, readValid1;
  logic [DW-1:0] readData0, readData1;
  logic          memWriteEnable;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData;
  logic [DW-1:0] memReadData;

  logic [DW-1:0] mem     [16];
  logic [DW-1:0] ref_mem [16];

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } resp_t;
  resp_t exp_q[$];

  int   n_cmp    = 0;
  int   n_bad    = 0;
  logic tb_last  = 1'b1;
  int   last_win = -1;
  bit   mon_en   = 1'b0;

  mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .writeEnable0   (writeEnable0),
    .address0       (address0),
    .writeData0     (writeData0),
    .grant0         (grant0),
    .readData0      (readData0),
    .readValid0     (readValid0),
    .req1           (req1),
    .writeEnable1   (writeEnable1),
    .address1       (address1),
    .writeData1     (writeData1),
    .grant1         (grant1),
    .readData1      (readData1),
    .readValid1     (readValid1),
    .memWriteEnable (memWriteEnable),
    .memAddress     (memAddress),
    .memWriteData   (memWriteData),
    .memReadData    (memReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWriteEnable) mem[memAddress] <= memWriteData;
    memReadData <= mem[memAddress];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Response monitor: samples mid-cycle, after the responses from the last edge have settled.
  always begin
    resp_t e;
    @(posedge clk);
    #3;
    if (mon_en && !reset) begin
      check_eq("valid_both", 32'(readValid0 & readValid1), 0);
      if (!readValid0) check_eq("rdata0_idle", 32'(readData0), 0);
      if (!readValid1) check_eq("rdata1_idle", 32'(readData1), 0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("resp_valid", 32'({readValid1, readValid0}), e.id ? 32'd2 : 32'd1);
        check_eq("resp_data", 32'(e.id ? readData1 : readData0), 32'(e.data));
      end else begin
        check_eq("no_resp", 32'({readValid1, readValid0}), 0);
      end
    end
  end

  // Drives one cycle of requests (called at posedge+1) and checks the grant against the model.
  task automatic step(input logic rq0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic rq1, input logic w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int            win;
    logic          we;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    req0 = rq0; writeEnable0 = w0; address0 = a0; writeData0 = d0;
    req1 = rq1; writeEnable1 = w1; address1 = a1; writeData1 = d1;
    if (rq0 && rq1) win = tb_last ? 0 : 1;
    else if (rq0)   win = 0;
    else if (rq1)   win = 1;
    else            win = -1;
    @(negedge clk);
    check_eq("grant0", 32'(grant0), 32'(win == 0));
    check_eq("grant1", 32'(grant1), 32'(win == 1));
    if (win >= 0) begin
      we = (win == 0) ? w0 : w1;
      ad = (win == 0) ? a0 : a1;
      wd = (win == 0) ? d0 : d1;
      check_eq("mem_we", 32'(memWriteEnable), 32'(we));
      check_eq("mem_addr", 32'(memAddress), 32'(ad));
      check_eq("mem_wdata", 32'(memWriteData), 32'(wd));
      if (we) ref_mem[ad] = wd;
      else    exp_q.push_back('{id: win[0], data: ref_mem[ad]});
      tb_last = win[0];
    end else begin
      check_eq("idle_we", 32'(memWriteEnable), 0);
      check_eq("idle_addr", 32'(memAddress), 0);
      check_eq("idle_wdata", 32'(memWriteData), 0);
    end
    last_win = win;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic          h0, h1, r_rq0, r_rq1, r_w0, r_w1;
  logic [AW-1:0] r_a0, r_a1;
  logic [DW-1:0] r_d0, r_d1;

  initial begin
    // Reset with both requesters already asking (writes that also preload 2 and 5).
    reset = 1'b1;
    req0 = 1'b1; writeEnable0 = 1'b1; address0 = 4'd2; writeData0 = 8'h11;
    req1 = 1'b1; writeEnable1 = 1'b1; address1 = 4'd5; writeData1 = 8'h22;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant0", 32'(grant0), 0);
    check_eq("rst_grant1", 32'(grant1), 0);
    check_eq("rst_mem_we", 32'(memWriteEnable), 0);
    check_eq("rst_mem_addr", 32'(memAddress), 0);
    check_eq("rst_valid", 32'({readValid1, readValid0}), 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    step(1'b1, 1'b1, 4'd2, 8'h11, 1'b1, 1'b1, 4'd5, 8'h22);
    check_eq("first_winner", 32'(last_win), 0);
    step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd5, 8'h22);

    for (int i = 0; i < 16; i++) begin
      if (i != 2 && i != 5) step(1'b1, 1'b1, 4'(i), 8'(i * 7 + 3), 1'b0, 1'b0, '0, '0);
    end

    // Write then read-back by requester 0 alone.
    step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, '0, '0);
    idle();

    // Both requesters reading continuously: grants must alternate.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00);
    end
    idle();

    // Write by 1 races a read of the same address by 0, with lastGrant = 0.
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b1, 4'd7, 8'h3C);
    check_eq("raw_first", 32'(last_win), 1);
    step(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, '0, '0);
    check_eq("raw_data_model", 32'(ref_mem[7]), 32'h3C);
    idle();

    // Reset arriving while requester 1's read response is on the bus.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 4'd5, 8'h00);
    req1 = 1'b0;
    #3;
    check_eq("pre_rst_valid1", 32'(readValid1), 1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid1", 32'(readValid1), 0);
    check_eq("async_rst_rdata1", 32'(readData1), 0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_valid1", 32'(readValid1), 0);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    tb_last = 1'b1;
    exp_q.delete();
    step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00);
    check_eq("post_rst_winner", 32'(last_win), 0);
    idle();

    // Idle cycles must not disturb lastGrant.
    step(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, '0, '0);
    repeat (4) idle();
    step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd5, 8'h00);
    check_eq("after_idle_winner", 32'(last_win), 1);
    idle();

    // Random traffic; a requester keeps its request stable until granted.
    h0 = 1'b0;
    h1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!h0) begin
        r_rq0 = 1'($urandom_range(0, 1));
        r_w0  = ($urandom_range(0, 3) == 0);
        r_a0  = 4'($urandom_range(0, 15));
        r_d0  = 8'($urandom);
      end
      if (!h1) begin
        r_rq1 = 1'($urandom_range(0, 1));
        r_w1  = ($urandom_range(0, 3) == 0);
        r_a1  = 4'($urandom_range(0, 15));
        r_d1  = 8'($urandom);
      end
      step(r_rq0, r_w0, r_a0, r_d0, r_rq1, r_w1, r_a1, r_d1);
      h0 = r_rq0 && (last_win != 0);
      h1 = r_rq1 && (last_win != 1);
    end
    repeat (2) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
